// File: rtl/itr_perm_seq_if.sv
// rtl/itr_perm_seq_if.sv - handshake/select bundle between the FFT controller and the iteration/permutation sequencer
// ERR is present only when ITR_PERM_SEQ_ERR_EN is defined.
interface itr_perm_seq_if;
  logic       start;
  logic       vld_iobuf;
  logic       vld_fsc;
  logic       sel_itr;
  logic       sel_permr;
  logic       vld_out;
  logic [3:0] stg;
  logic       busy;
  logic       done;
`ifdef ITR_PERM_SEQ_ERR_EN
  logic       err;

  modport master (
    output start, vld_iobuf, vld_fsc,
    input  sel_itr, sel_permr, vld_out, stg, busy, done, err
  );

  modport slave (
    input  start, vld_iobuf, vld_fsc,
    output sel_itr, sel_permr, vld_out, stg, busy, done, err
  );
`else
  modport master (
    output start, vld_iobuf, vld_fsc,
    input  sel_itr, sel_permr, vld_out, stg, busy, done
  );

  modport slave (
    input  start, vld_iobuf, vld_fsc,
    output sel_itr, sel_permr, vld_out, stg, busy, done
  );
`endif
endinterface

// File: rtl/itr_perm_seq.sv
// rtl/itr_perm_seq.sv - iteration-source / pair-swap sequencer for the FFT front end
// Optional sticky wrong-source flag ERR enabled by ITR_PERM_SEQ_ERR_EN.
module itr_perm_seq #(
  parameter int LOG2N   = 6,
  parameter int NSTG    = 6,
  parameter int GAP_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  itr_perm_seq_if.slave bus
);

  localparam int             KW       = LOG2N - 1;
  localparam logic [KW-1:0]  K_LAST   = '1;
  localparam logic [3:0]     STG_LAST = 4'(NSTG - 1);
  localparam logic [3:0]     GAP_LAST = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    stg_q, stg_d;
  logic [KW-1:0] k_q, k_d;
  logic [3:0]    gap_q, gap_d;

  logic          cur_vld;
  logic          in_run;
  logic          in_gap;
  logic [KW-1:0] k_shift;

  assign in_run  = (state_q == S_RUN);
  assign in_gap  = (state_q == S_GAP);
  assign cur_vld = (stg_q == 4'd0) ? bus.vld_iobuf : bus.vld_fsc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      stg_q   <= 4'd0;
      k_q     <= '0;
      gap_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      stg_q   <= stg_d;
      k_q     <= k_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stg_d   = stg_q;
    k_d     = k_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          stg_d   = 4'd0;
          k_d     = '0;
          gap_d   = 4'd0;
        end
      end
      S_RUN: begin
        if (cur_vld) begin
          k_d = k_q + 1'b1;
          if (k_q == K_LAST) begin
            k_d = '0;
            if (stg_q == STG_LAST) begin
              state_d = S_FIN;
            end else if (GAP_CYC == 0) begin
              stg_d = stg_q + 4'd1;
            end else begin
              state_d = S_GAP;
              gap_d   = 4'd0;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_RUN;
          stg_d   = stg_q + 4'd1;
          gap_d   = 4'd0;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        stg_d   = 4'd0;
        k_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Stage s swaps on pair-index bit s-1; shifting past the counter width yields 0 for late stages.
  assign k_shift = k_q >> (stg_q - 4'd1);

  assign bus.stg       = stg_q;
  assign bus.busy      = in_run | in_gap;
  assign bus.done      = (state_q == S_FIN);
  assign bus.sel_itr   = (in_run | in_gap) & (stg_q != 4'd0);
  assign bus.sel_permr = in_run & (stg_q != 4'd0) & k_shift[0];
  assign bus.vld_out   = in_run & cur_vld;

`ifdef ITR_PERM_SEQ_ERR_EN
  logic err_q, err_d;
  logic wrong_vld;

  assign wrong_vld = (in_run & ((stg_q == 4'd0) ? bus.vld_fsc : bus.vld_iobuf))
                   | (in_gap & (bus.vld_fsc | bus.vld_iobuf));

  always_comb begin
    err_d = err_q | wrong_vld;
    if (state_q == S_IDLE && bus.start) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_itr_perm_seq.sv
// tb/tb_itr_perm_seq.sv - directed scoreboard bench for itr_perm_seq
// ERR checks are compiled in when ITR_PERM_SEQ_ERR_EN is defined.
module tb_itr_perm_seq;

  localparam int LOG2N   = 6;
  localparam int NSTG    = 6;
  localparam int GAP_CYC = 2;
  localparam int NPAIR   = 1 << (LOG2N - 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  itr_perm_seq_if bus();

  itr_perm_seq #(
    .LOG2N  (LOG2N),
    .NSTG   (NSTG),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] sb[$];

  int cyc;
  int cur_mode;
  int busy_cyc;
  int done_cnt;
  int done_idx;
  int gap_cyc;
  int s0_last;
  int mirror_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_pair(input int s, input int k);
    logic itr;
    logic permr;
    itr   = (s >= 1);
    permr = 1'b0;
    if (s >= 1 && (s - 1) < (LOG2N - 1)) permr = ((k >> (s - 1)) & 1) != 0;
    return {4'(s), itr, permr};
  endfunction

  function automatic logic [8:0] all_outs();
    return {bus.sel_itr, bus.sel_permr, bus.vld_out, bus.stg, bus.busy, bus.done};
  endfunction

  task automatic drive(input int mode);
    case (mode)
      0: begin bus.vld_iobuf = 1'b1; bus.vld_fsc = 1'b1; end
      1: begin bus.vld_iobuf = (cyc >= 0) && (cyc % 2 == 1); bus.vld_fsc = 1'b1; end
      default: begin
        bus.vld_iobuf = (cyc >= 0) && (cyc < NPAIR);
        bus.vld_fsc   = (cyc == 5) || (cyc >= NPAIR + GAP_CYC);
      end
    endcase
  endtask

  // Sample at negedge, score any presented pair, then return just after the next rising edge.
  task automatic step();
    logic [5:0] e;
    @(negedge clk);
    if (bus.vld_out) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pair", {bus.stg, bus.sel_itr, bus.sel_permr}, e);
      end
      if (bus.stg == 4'd0) s0_last = cyc;
    end
    if (cur_mode == 1 && cyc >= 0 && cyc < 2 * NPAIR && bus.vld_out !== bus.vld_iobuf) mirror_err++;
    if (bus.busy) busy_cyc++;
    if (bus.busy && !bus.vld_out) gap_cyc++;
    if (bus.done) begin
      done_cnt++;
      if (done_idx < 0) done_idx = cyc + 1;
      check("busy_low_at_done", bus.busy, 32'd0);
`ifdef ITR_PERM_SEQ_ERR_EN
      if (cur_mode == 2) check("err_held_at_done", bus.err, 32'd1);
`endif
    end
`ifdef ITR_PERM_SEQ_ERR_EN
    if (cur_mode == 2 && cyc == 5) check("err_before_set", bus.err, 32'd0);
    if (cur_mode == 2 && cyc == 6) check("err_set", bus.err, 32'd1);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic run_xfer(input int mode, input int restart_at, input int rst_at);
    cur_mode   = mode;
    busy_cyc   = 0;
    done_cnt   = 0;
    done_idx   = -1;
    gap_cyc    = 0;
    s0_last    = -1;
    mirror_err = 0;
    sb.delete();
    for (int s = 0; s < NSTG; s++)
      for (int k = 0; k < NPAIR; k++)
        sb.push_back(exp_pair(s, k));
    cyc = -1;
    drive(mode);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      cyc = i;
      drive(mode);
      bus.start = (i == restart_at);
      if (i == restart_at) check("stg_at_restart", bus.stg, 32'd2);
      if (i == rst_at) begin
        check("stg_before_rst", bus.stg, 32'd3);
        #1 rst = 1'b1;
        #1 check("rst_async_outs", all_outs(), 32'd0);
        step();
        step();
        rst = 1'b0;
        sb.delete();
        return;
      end
      step();
      if (done_cnt > 0) break;
    end
    bus.start = 1'b0;
    if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 4; i++) step();
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.vld_iobuf = 1'b0;
    bus.vld_fsc   = 1'b0;
    cur_mode      = 0;
    cyc           = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", all_outs(), 32'd0);
`ifdef ITR_PERM_SEQ_ERR_EN
    check("reset_err", bus.err, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Continuous valids: 32-pair stages, 2-cycle gaps, DONE on the 203rd cycle counted from BUSY rise.
    run_xfer(0, -1, -1);
    check("full_done_cnt", done_cnt, 32'd1);
    check("full_done_idx", done_idx, 32'(NSTG * NPAIR + (NSTG - 1) * GAP_CYC + 1));
    check("full_busy_cyc", busy_cyc, 32'(NSTG * NPAIR + (NSTG - 1) * GAP_CYC));
    check("full_gap_cyc", gap_cyc, 32'((NSTG - 1) * GAP_CYC));
    check("full_sb_empty", sb.size(), 32'd0);

    // IOBUF valid every other cycle in stage 0, FSC held high throughout.
    run_xfer(1, -1, -1);
    check("tog_s0_span", s0_last + 1, 32'(2 * NPAIR));
    check("tog_mirror", mirror_err, 32'd0);
    check("tog_done_cnt", done_cnt, 32'd1);
    check("tog_done_idx", done_idx, 32'(2 * NPAIR + (NSTG - 1) * NPAIR + (NSTG - 1) * GAP_CYC + 1));
    check("tog_sb_empty", sb.size(), 32'd0);

    // Second START at stage 2, pair 10 must not disturb the transform.
    run_xfer(0, 2 * (NPAIR + GAP_CYC) + 10, -1);
    check("restart_done_cnt", done_cnt, 32'd1);
    check("restart_done_idx", done_idx, 32'(NSTG * NPAIR + (NSTG - 1) * GAP_CYC + 1));
    check("restart_sb_empty", sb.size(), 32'd0);

    // Reset in stage 3, then a clean transform.
    run_xfer(0, -1, 3 * (NPAIR + GAP_CYC) + 5);
    check("rst_no_done", done_cnt, 32'd0);
    @(negedge clk);
    check("rst_idle_outs", all_outs(), 32'd0);
    @(posedge clk);
    #1;
    run_xfer(0, -1, -1);
    check("post_rst_done_cnt", done_cnt, 32'd1);
    check("post_rst_done_idx", done_idx, 32'(NSTG * NPAIR + (NSTG - 1) * GAP_CYC + 1));
    check("post_rst_sb_empty", sb.size(), 32'd0);

`ifdef ITR_PERM_SEQ_ERR_EN
    run_xfer(0, -1, -1);
    check("err_clean_run", bus.err, 32'd0);
    run_xfer(2, -1, -1);
    check("err_done_cnt", done_cnt, 32'd1);
    check("err_sticky_idle", bus.err, 32'd1);
    cur_mode      = 0;
    bus.vld_iobuf = 1'b0;
    bus.vld_fsc   = 1'b0;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    @(negedge clk);
    check("err_cleared_by_start", bus.err, 32'd0);
    check("err_busy_after_start", bus.busy, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
